// File: rtl/uv_pred_ssd_pkg.sv
// Shared sizes, FSM encoding and the per-pixel squared-difference helper
// for the chroma prediction SSD block.
package uv_pred_ssd_pkg;

  localparam int unsigned BIT_WIDTH  = 8;
  localparam int unsigned BLOCK_SIZE = 8;
  localparam int unsigned UV_SIZE    = 16;
  localparam int unsigned SSD_WIDTH  = 24;
  localparam int unsigned MODE_W     = 2;

  localparam int unsigned ROW_W     = BIT_WIDTH * UV_SIZE;
  localparam int unsigned BLK_W     = ROW_W * BLOCK_SIZE;
  localparam int unsigned ROW_SSD_W = 20;
  localparam int unsigned SQ_W      = 2 * BIT_WIDTH;
  localparam int unsigned ROW_CNT_W = $clog2(BLOCK_SIZE);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Square of a signed difference is formed from its magnitude so the
  // product stays an unsigned SQ_W-bit value.
  function automatic logic [SQ_W-1:0] pix_sq(input logic [BIT_WIDTH-1:0] s,
                                             input logic [BIT_WIDTH-1:0] p);
    logic signed [BIT_WIDTH:0] diff;
    logic [BIT_WIDTH-1:0]      mag;
    diff = $signed({1'b0, s}) - $signed({1'b0, p});
    mag  = diff[BIT_WIDTH] ? BIT_WIDTH'(-diff) : diff[BIT_WIDTH-1:0];
    return {{BIT_WIDTH{1'b0}}, mag} * {{BIT_WIDTH{1'b0}}, mag};
  endfunction

endpackage

// File: rtl/uv_row_ssd.sv
// Combinational SSD of one packed chroma row: U in cols 0..7, V in cols 8..15.
module uv_row_ssd
  import uv_pred_ssd_pkg::*;
(
  input  logic [ROW_W-1:0]     pred_row,
  input  logic [ROW_W-1:0]     src_row,
  output logic [ROW_SSD_W-1:0] row_ssd_u,
  output logic [ROW_SSD_W-1:0] row_ssd_v
);

  always_comb begin
    row_ssd_u = '0;
    row_ssd_v = '0;
    for (int unsigned c = 0; c < BLOCK_SIZE; c++) begin
      row_ssd_u = row_ssd_u + ROW_SSD_W'(pix_sq(src_row[c*BIT_WIDTH +: BIT_WIDTH],
                                                pred_row[c*BIT_WIDTH +: BIT_WIDTH]));
      row_ssd_v = row_ssd_v + ROW_SSD_W'(pix_sq(src_row[(c+BLOCK_SIZE)*BIT_WIDTH +: BIT_WIDTH],
                                                pred_row[(c+BLOCK_SIZE)*BIT_WIDTH +: BIT_WIDTH]));
    end
  end

endmodule

// File: rtl/uv_pred_ssd.sv
// Chroma prediction SSD: accumulates one row per cycle over 8 cycles, then
// publishes U/V/total SSD and tracks the cheapest mode since the last in_first.
module uv_pred_ssd
  import uv_pred_ssd_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_first,
  input  logic [MODE_W-1:0]    in_mode,
  input  logic [BLK_W-1:0]     pred,
  input  logic [BLK_W-1:0]     src,
  output logic                 done,
  output logic [SSD_WIDTH-1:0] ssd_u,
  output logic [SSD_WIDTH-1:0] ssd_v,
  output logic [SSD_WIDTH-1:0] ssd_total,
  output logic [SSD_WIDTH-1:0] best_ssd,
  output logic [MODE_W-1:0]    best_mode
);

  state_t                 state_q;
  logic [BLK_W-1:0]       pred_q, src_q;
  logic [MODE_W-1:0]      mode_q;
  logic                   first_q;
  logic [ROW_CNT_W-1:0]   row_q;
  logic [SSD_WIDTH-1:0]   acc_u_q, acc_v_q;
  logic                   ready_q, done_q;
  logic [SSD_WIDTH-1:0]   ssd_u_q, ssd_v_q, ssd_total_q, best_ssd_q;
  logic [MODE_W-1:0]      best_mode_q;

  logic [ROW_W-1:0]       pred_row, src_row;
  logic [ROW_SSD_W-1:0]   row_u, row_v;
  logic [SSD_WIDTH-1:0]   acc_u_d, acc_v_d, total_d;
  logic                   accept, last_row;

  assign pred_row = pred_q[row_q*ROW_W +: ROW_W];
  assign src_row  = src_q[row_q*ROW_W +: ROW_W];

  uv_row_ssd u_row (
    .pred_row  (pred_row),
    .src_row   (src_row),
    .row_ssd_u (row_u),
    .row_ssd_v (row_v)
  );

  assign acc_u_d  = acc_u_q + SSD_WIDTH'(row_u);
  assign acc_v_d  = acc_v_q + SSD_WIDTH'(row_v);
  assign total_d  = acc_u_d + acc_v_d;
  assign accept   = in_valid & ready_q;
  assign last_row = (row_q == ROW_CNT_W'(BLOCK_SIZE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pred_q      <= '0;
      src_q       <= '0;
      mode_q      <= '0;
      first_q     <= 1'b0;
      row_q       <= '0;
      acc_u_q     <= '0;
      acc_v_q     <= '0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      ssd_u_q     <= '0;
      ssd_v_q     <= '0;
      ssd_total_q <= '0;
      best_ssd_q  <= '0;
      best_mode_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            pred_q  <= pred;
            src_q   <= src;
            mode_q  <= in_mode;
            first_q <= in_first;
            row_q   <= '0;
            acc_u_q <= '0;
            acc_v_q <= '0;
            ready_q <= 1'b0;
            state_q <= ST_ACC;
          end else begin
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        ST_ACC: begin
          acc_u_q <= acc_u_d;
          acc_v_q <= acc_v_d;
          row_q   <= row_q + 1'b1;
          // The last row is folded in directly so results land on the same edge.
          if (last_row) begin
            ssd_u_q     <= acc_u_d;
            ssd_v_q     <= acc_v_d;
            ssd_total_q <= total_d;
            if (first_q || (total_d < best_ssd_q)) begin
              best_ssd_q  <= total_d;
              best_mode_q <= mode_q;
            end
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = ready_q;
  assign done      = done_q;
  assign ssd_u     = ssd_u_q;
  assign ssd_v     = ssd_v_q;
  assign ssd_total = ssd_total_q;
  assign best_ssd  = best_ssd_q;
  assign best_mode = best_mode_q;

endmodule

// File: tb/tb_uv_pred_ssd.sv
// Randomised self-checking bench for uv_pred_ssd against a plain-arithmetic SSD
// and best-mode reference model.
module tb_uv_pred_ssd;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_first;
  logic [1:0]    in_mode;
  logic [1023:0] pred, src;
  logic          done;
  logic [23:0]   ssd_u, ssd_v, ssd_total, best_ssd;
  logic [1:0]    best_mode;

  int checks = 0;
  int errors = 0;

  longint m_best_ssd  = 0;
  longint m_best_mode = 0;

  uv_pred_ssd dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_first  (in_first),
    .in_mode   (in_mode),
    .pred      (pred),
    .src       (src),
    .done      (done),
    .ssd_u     (ssd_u),
    .ssd_v     (ssd_v),
    .ssd_total (ssd_total),
    .best_ssd  (best_ssd),
    .best_mode (best_mode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void ref_ssd(input logic [1023:0] p, input logic [1023:0] s,
                                  output longint su, output longint sv);
    su = 0;
    sv = 0;
    for (int j = 0; j < 8; j++) begin
      for (int c = 0; c < 16; c++) begin
        int d;
        d = int'(s[(j*16+c)*8 +: 8]) - int'(p[(j*16+c)*8 +: 8]);
        if (c < 8) su += d * d;
        else       sv += d * d;
      end
    end
  endfunction

  function automatic logic [1023:0] fill(input logic [7:0] v);
    logic [1023:0] b;
    for (int i = 0; i < 128; i++) b[i*8 +: 8] = v;
    return b;
  endfunction

  function automatic logic [1023:0] rnd_blk();
    logic [1023:0] b;
    for (int i = 0; i < 32; i++) b[i*32 +: 32] = $urandom();
    return b;
  endfunction

  function automatic logic [1023:0] set_px(input logic [1023:0] b, input int j, input int c,
                                           input logic [7:0] v);
    b[(j*16+c)*8 +: 8] = v;
    return b;
  endfunction

  // Results check at the done cycle; updates the best-mode model first.
  task automatic check_result(input logic [1023:0] p, input logic [1023:0] s,
                              input int md, input bit fst);
    longint su, sv, tot;
    ref_ssd(p, s, su, sv);
    tot = su + sv;
    if (fst || tot < m_best_ssd) begin
      m_best_ssd  = tot;
      m_best_mode = md;
    end
    chk("ssd_u", ssd_u, su);
    chk("ssd_v", ssd_v, sv);
    chk("ssd_total", ssd_total, tot);
    chk("best_ssd", best_ssd, m_best_ssd);
    chk("best_mode", best_mode, m_best_mode);
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_ready"}, in_ready, 1);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ssd_u"}, ssd_u, 0);
    chk({tag, "_ssd_v"}, ssd_v, 0);
    chk({tag, "_total"}, ssd_total, 0);
    chk({tag, "_best"}, best_ssd, 0);
    chk({tag, "_bmode"}, best_mode, 0);
  endtask

  task automatic run_cand(input logic [1023:0] p, input logic [1023:0] s,
                          input int md, input bit fst);
    @(negedge clk);
    chk("ready_idle", in_ready, 1);
    pred = p; src = s; in_mode = 2'(md); in_first = fst; in_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        in_valid = 1'b0;
        pred = ~p; src = rnd_blk(); in_mode = ~in_mode; in_first = ~fst;
      end
      chk("acc_ready", in_ready, 0);
      chk("acc_done", done, 0);
    end
    @(negedge clk);
    chk("done_at_9", done, 1);
    chk("ready_done", in_ready, 1);
    check_result(p, s, md, fst);
    @(negedge clk);
    chk("done_pulse", done, 0);
  endtask

  task automatic run_stream(input int n);
    logic [1023:0] cp[$], cs[$];
    int cm[$];
    bit cf[$];
    int idx = 0;
    for (int i = 0; i < n; i++) begin
      cp.push_back(rnd_blk());
      cs.push_back(rnd_blk());
      cm.push_back($urandom_range(0, 3));
      cf.push_back(i == 0 || $urandom_range(0, 2) == 0);
    end
    @(negedge clk);
    pred = cp[0]; src = cs[0]; in_mode = 2'(cm[0]); in_first = cf[0]; in_valid = 1'b1;
    for (int k = 1; k <= 9 * n; k++) begin
      @(negedge clk);
      chk("stream_done", done, (k % 9) == 0);
      chk("stream_ready", in_ready, (k % 9) == 0);
      if (k % 9 == 0) begin
        check_result(cp[idx], cs[idx], cm[idx], cf[idx]);
        idx++;
        if (idx < n) begin
          pred = cp[idx]; src = cs[idx]; in_mode = 2'(cm[idx]); in_first = cf[idx];
        end else begin
          in_valid = 1'b0;
        end
      end else begin
        pred = rnd_blk(); src = rnd_blk();
        in_mode = 2'($urandom_range(0, 3)); in_first = 1'($urandom_range(0, 1));
      end
    end
    @(negedge clk);
    chk("stream_end_done", done, 0);
  endtask

  task automatic run_reset_mid();
    logic [1023:0] p, s;
    p = rnd_blk(); s = rnd_blk();
    @(negedge clk);
    pred = p; src = s; in_mode = 2'd1; in_first = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check_idle_zero("rst_async");
    m_best_ssd = 0;
    m_best_mode = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_zero("rst_release");
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("rst_no_done", done, 0);
      chk("rst_ready", in_ready, 1);
    end
  endtask

  initial begin
    logic [1023:0] base, p, s, lp, ls;
    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_mode = '0;
    pred = '0; src = '0;
    repeat (2) @(negedge clk);
    check_idle_zero("in_reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle_zero("after_reset");

    // Identical blocks give zero cost.
    run_cand(fill(8'h80), fill(8'h80), 0, 1'b1);
    chk("t1_total", ssd_total, 0);
    chk("t1_best", best_ssd, 0);

    // Worst case: every pixel differs by 255.
    run_cand(fill(8'h00), fill(8'hFF), 1, 1'b0);
    chk("t2_u_max", ssd_u, 4161600);
    chk("t2_v_max", ssd_v, 4161600);
    chk("t2_total_max", ssd_total, 8323200);

    // Single-pixel differences, last V column of the last row included.
    base = fill(8'h55);
    s = set_px(base, 3, 5, 8'h5F);
    s = set_px(s, 7, 15, 8'h52);
    run_cand(base, s, 2, 1'b1);
    chk("t3_u", ssd_u, 100);
    chk("t3_v", ssd_v, 9);
    chk("t3_total", ssd_total, 109);

    // Mode sweep: 500, 300, 300 (tie keeps mode 1), 700, then restart at 900.
    base = fill(8'h40);
    s = set_px(set_px(base, 0, 0, 8'h54), 0, 1, 8'h4A);
    run_cand(base, s, 0, 1'b1);
    chk("t4_500", ssd_total, 500);
    s = set_px(set_px(set_px(base, 0, 0, 8'h4A), 0, 1, 8'h4A), 0, 2, 8'h4A);
    run_cand(base, s, 1, 1'b0);
    run_cand(base, s, 2, 1'b0);
    s = set_px(s, 0, 3, 8'h54);
    run_cand(base, s, 3, 1'b0);
    chk("t4_700", ssd_total, 700);
    chk("t4_best_ssd", best_ssd, 300);
    chk("t4_best_mode", best_mode, 1);
    s = set_px(base, 2, 9, 8'h5E);
    run_cand(base, s, 3, 1'b1);
    chk("t4_restart_ssd", best_ssd, 900);
    chk("t4_restart_mode", best_mode, 3);

    run_reset_mid();

    run_stream(3);

    lp = rnd_blk(); ls = rnd_blk();
    for (int i = 0; i < 24; i++) begin
      if (i > 0 && $urandom_range(0, 4) == 0) begin
        p = lp; s = ls;
      end else begin
        p = rnd_blk();
        s = p;
        if ($urandom_range(0, 1) == 0) s = rnd_blk();
        else for (int k = 0; k < 4; k++)
          s = set_px(s, $urandom_range(0, 7), $urandom_range(0, 15), 8'($urandom()));
      end
      run_cand(p, s, $urandom_range(0, 3), i == 0 || $urandom_range(0, 3) == 0);
      lp = p; ls = s;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
